// File: rtl/arbiter.sv
// rtl/arbiter.sv - registered fixed-priority / round-robin arbiter
// with optional grant holding until the request drops or an acknowledge arrives.
module arbiter #(
   parameter int PORTS                 = 4,
   parameter int ARB_TYPE_ROUND_ROBIN  = 0,
   parameter int ARB_BLOCK             = 0,
   parameter int ARB_BLOCK_ACK         = 1,
   parameter int ARB_LSB_HIGH_PRIORITY = 0,
   localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] request,
   input  logic [PORTS-1:0] acknowledge,
   output logic [PORTS-1:0] grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_encoded
);

   logic [PORTS-1:0] grant_reg;
   logic [PORTS-1:0] grant_next;
   logic             grant_valid_reg;
   logic             grant_valid_next;
   logic [IDX_W-1:0] grant_encoded_reg;
   logic [IDX_W-1:0] grant_encoded_next;
   logic [PORTS-1:0] mask_reg;
   logic [PORTS-1:0] mask_next;

   logic [PORTS-1:0] masked_request;
   logic [PORTS-1:0] pick_vec;
   logic [IDX_W-1:0] pick_idx;
   logic             hold;

   // Round-robin falls back to the full request vector once the mask window is empty.
   always_comb begin
      masked_request = request & mask_reg;
      if ((ARB_TYPE_ROUND_ROBIN != 0) && (masked_request != '0)) begin
         pick_vec = masked_request;
      end else begin
         pick_vec = request;
      end
   end

   // Later loop iterations win, so the scan order sets the priority direction.
   always_comb begin
      pick_idx = '0;
      if (ARB_LSB_HIGH_PRIORITY != 0) begin
         for (int i = PORTS - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
               pick_idx = IDX_W'(i);
            end
         end
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (pick_vec[i]) begin
               pick_idx = IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      hold = 1'b0;
      if (ARB_BLOCK != 0) begin
         if (ARB_BLOCK_ACK != 0) begin
            hold = grant_valid_reg && ((grant_reg & acknowledge) == '0);
         end else begin
            hold = (grant_reg & request) != '0;
         end
      end
   end

   always_comb begin
      grant_next         = grant_reg;
      grant_valid_next   = grant_valid_reg;
      grant_encoded_next = grant_encoded_reg;
      mask_next          = mask_reg;
      if (!hold) begin
         grant_next         = '0;
         grant_valid_next   = 1'b0;
         grant_encoded_next = '0;
         if (pick_vec != '0) begin
            grant_valid_next   = 1'b1;
            grant_encoded_next = pick_idx;
            for (int j = 0; j < PORTS; j++) begin
               grant_next[j] = (j == int'(pick_idx));
               if (ARB_LSB_HIGH_PRIORITY != 0) begin
                  mask_next[j] = (j > int'(pick_idx));
               end else begin
                  mask_next[j] = (j < int'(pick_idx));
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_reg         <= '0;
         grant_valid_reg   <= 1'b0;
         grant_encoded_reg <= '0;
         mask_reg          <= '0;
      end else begin
         grant_reg         <= grant_next;
         grant_valid_reg   <= grant_valid_next;
         grant_encoded_reg <= grant_encoded_next;
         mask_reg          <= mask_next;
      end
   end

   assign grant         = grant_reg;
   assign grant_valid   = grant_valid_reg;
   assign grant_encoded = grant_encoded_reg;

endmodule

// File: tb/tb_arbiter.sv
// tb/tb_arbiter.sv - scoreboard bench for arbiter across four parameter sets
// (blocking on request, round-robin, blocking on acknowledge, LSB fixed priority).
module tb_arbiter;

   localparam int P = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [P-1:0] request = '0;
   logic [P-1:0] acknowledge = '0;

   logic [P-1:0] g_blk, g_rr, g_ack, g_lsb;
   logic         v_blk, v_rr, v_ack, v_lsb;
   logic [4:0]   e_blk, e_rr, e_ack, e_lsb;

   always #5 clk = ~clk;

   arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
             .ARB_LSB_HIGH_PRIORITY(0)) u_blk (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g_blk), .grant_valid(v_blk), .grant_encoded(e_blk));

   arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
             .ARB_LSB_HIGH_PRIORITY(0)) u_rr (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr));

   arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
             .ARB_LSB_HIGH_PRIORITY(0)) u_ack (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g_ack), .grant_valid(v_ack), .grant_encoded(e_ack));

   arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
             .ARB_LSB_HIGH_PRIORITY(1)) u_lsb (
      .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
      .grant(g_lsb), .grant_valid(v_lsb), .grant_encoded(e_lsb));

   typedef struct {
      string        tag;
      int           sel;
      logic [P-1:0] g;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   logic [P-1:0] rr_mask;
   logic [P-1:0] r_req;
   logic [P-1:0] r_vec;
   logic [P-1:0] r_exp;
   int           r_hi;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] idx_of(input logic [P-1:0] g);
      idx_of = '0;
      for (int i = 0; i < P; i++) begin
         if (g[i]) idx_of = 5'(i);
      end
   endfunction

   task automatic check_outputs(input string tag, input int sel, input logic [P-1:0] g);
      logic [P-1:0] ag;
      logic         av;
      logic [4:0]   ae;
      case (sel)
         0:       begin ag = g_blk; av = v_blk; ae = e_blk; end
         1:       begin ag = g_rr;  av = v_rr;  ae = e_rr;  end
         2:       begin ag = g_ack; av = v_ack; ae = e_ack; end
         default: begin ag = g_lsb; av = v_lsb; ae = e_lsb; end
      endcase
      check_val({tag, ".grant"}, ag, g);
      check_val({tag, ".valid"}, 32'(av), 32'(g != '0));
      check_val({tag, ".enc"}, 32'(ae), 32'(idx_of(g)));
   endtask

   task automatic drive(input string tag, input int sel, input logic [P-1:0] req,
                        input logic [P-1:0] ack, input logic [P-1:0] exp_g);
      exp_t e;
      request     = req;
      acknowledge = ack;
      e.tag = tag;
      e.sel = sel;
      e.g   = exp_g;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check_val({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_outputs(e.tag, e.sel, e.g);
      end
   endtask

   task automatic do_reset();
      request     = '0;
      acknowledge = '0;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #2;
      rst = 1'b1;
      #1;
      for (int s = 0; s < 4; s++) check_outputs($sformatf("reset%0d", s), s, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // blocking on request
      drive("blk_first", 0, 32'h0000_0005, '0, 32'h0000_0004);
      drive("blk_hold", 0, 32'h8000_0004, '0, 32'h0000_0004);
      drive("blk_release", 0, 32'h8000_0000, '0, 32'h8000_0000);
      drive("blk_idle", 0, 32'h0000_0000, '0, 32'h0000_0000);
      drive("blk_regrant", 0, 32'h0000_0004, '0, 32'h0000_0004);
      #2;
      rst = 1'b1;
      #1;
      check_outputs("async_rst", 0, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // round-robin
      do_reset();
      drive("rr0", 1, 32'h13, '0, 32'h10);
      drive("rr1", 1, 32'h13, '0, 32'h02);
      drive("rr2", 1, 32'h13, '0, 32'h01);
      drive("rr3", 1, 32'h13, '0, 32'h10);
      do_reset();
      drive("rr_after_rst", 1, 32'h13, '0, 32'h10);
      drive("rr_idle", 1, 32'h00, '0, 32'h00);
      drive("rr_mask_kept", 1, 32'h13, '0, 32'h02);

      do_reset();
      rr_mask = '0;
      for (int k = 0; k < 24; k++) begin
         r_req = $urandom & $urandom & $urandom;
         if (k % 7 == 3) r_req = '0;
         r_vec = ((r_req & rr_mask) != '0) ? (r_req & rr_mask) : r_req;
         r_exp = '0;
         if (r_vec != '0) begin
            r_hi = 0;
            for (int i = 0; i < P; i++) if (r_vec[i]) r_hi = i;
            r_exp   = 32'h1 << r_hi;
            rr_mask = (32'h1 << r_hi) - 32'h1;
         end
         drive($sformatf("rr_rand%0d", k), 1, r_req, '0, r_exp);
      end

      // blocking on acknowledge
      do_reset();
      drive("ack_first", 2, 32'h08, '0, 32'h08);
      drive("ack_hold0", 2, 32'h00, '0, 32'h08);
      drive("ack_hold1", 2, 32'h00, '0, 32'h08);
      drive("ack_release", 2, 32'h00, 32'h08, 32'h00);
      drive("ack_regrant", 2, 32'h08, '0, 32'h08);
      drive("ack_same_cycle", 2, 32'h02, 32'h08, 32'h02);
      drive("ack_hold_newreq", 2, 32'h40, '0, 32'h02);
      drive("ack_switch", 2, 32'h40, 32'h02, 32'h40);
      drive("ack_wrong_bit", 2, 32'h40, 32'h01, 32'h40);

      // LSB fixed priority
      do_reset();
      drive("lsb_first", 3, 32'h06, '0, 32'h02);
      drive("lsb_top", 3, 32'h8000_0000, '0, 32'h8000_0000);
      for (int k = 0; k < 16; k++) begin
         r_req = $urandom & $urandom;
         if (k % 5 == 2) r_req = '0;
         drive($sformatf("lsb_rand%0d", k), 3, r_req, '0, r_req & (~r_req + 32'h1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
